// File: rtl/rr_grant_arbiter8_if.sv
// rr_grant_arbiter8_if
//   Bundles the request/grant signals of the 8-way round-robin arbiter.
//   master : requester side (drives en/req, observes the grant).
//   slave  : arbiter side (samples en/req, drives the grant outputs).
//   en         1  new grants may be issued
//   req        8  request vector, bit i = requester i
//   gnt        8  registered one-hot grant, zero when idle
//   gnt_idx    3  binary owner index, meaningful while gnt_vld=1
//   gnt_vld    1  a grant is active (equals |gnt)
//   forced_rel 1  one-cycle pulse when a grant ended by hold timeout
interface rr_grant_arbiter8_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       forced_rel;

  modport master (
    output en,
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_vld,
    input  forced_rel
  );

  modport slave (
    input  en,
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_vld,
    output forced_rel
  );
endinterface

// File: rtl/rr_grant_arbiter8.sv
// rr_grant_arbiter8
//   Round-robin arbiter sharing one resource among 8 requesters. The winner
//   gets a registered one-hot grant plus its binary index. The owner keeps
//   the grant while it requests, up to MAX_HOLD consecutive cycles; a
//   timeout release is flagged by a one-cycle forced_rel pulse. Every grant
//   is followed by at least one idle cycle, and the search pointer moves to
//   the requester after the last owner.
// Ports
//   clk   in  rising-edge clock
//   rst   in  asynchronous, active-high reset
//   bus   slave modport of rr_grant_arbiter8_if (en, req in; gnt, gnt_idx,
//         gnt_vld, forced_rel out, all registered)
// Parameters
//   MAX_HOLD  max consecutive busy cycles per grant (>= 1)
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
module rr_grant_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_grant_arbiter8_if.slave   bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_p0, state_nxt;
  logic [2:0]       ptr_p0,   ptr_nxt;
  logic [CNT_W-1:0] hold_p0,  hold_nxt;
  logic [7:0]       gnt_p0,   gnt_nxt;
  logic [2:0]       idx_p0,   idx_nxt;
  logic             vld_p0,   vld_nxt;
  logic             frel_p0,  frel_nxt;

  logic [2:0]       winner;
  logic             owner_req;
  logic             hold_last;

  // First set bit of r when scanning p, p+1, ..., p+7 (mod 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] r,
                                         input logic [2:0] p);
    logic [2:0] idx;
    logic       found;
    rr_pick = 3'd0;
    found   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = p + 3'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] i);
    onehot8 = 8'h01 << i;
  endfunction

  assign winner    = rr_pick(bus.req, ptr_p0);
  assign owner_req = bus.req[idx_p0];
  assign hold_last = (hold_p0 == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    state_nxt = state_p0;
    ptr_nxt   = ptr_p0;
    hold_nxt  = hold_p0;
    idx_nxt   = idx_p0;
    vld_nxt   = vld_p0;
    frel_nxt  = 1'b0;

    case (state_p0)
      IDLE: begin
        vld_nxt = 1'b0;
        if (bus.en && (bus.req != 8'h00)) begin
          idx_nxt   = winner;
          vld_nxt   = 1'b1;
          hold_nxt  = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // A voluntary release wins over a coincident timeout, so forced_rel
        // only flags grants that were actually cut short.
        if (!owner_req || hold_last) begin
          frel_nxt  = owner_req;
          vld_nxt   = 1'b0;
          ptr_nxt   = idx_p0 + 3'd1;
          state_nxt = IDLE;
        end else begin
          hold_nxt = hold_p0 + CNT_W'(1);
        end
      end
    endcase

    gnt_nxt = vld_nxt ? onehot8(idx_nxt) : 8'h00;
  end

  // Stage p0: state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0 <= IDLE;
      ptr_p0   <= 3'd0;
      hold_p0  <= '0;
      gnt_p0   <= 8'h00;
      idx_p0   <= 3'd0;
      vld_p0   <= 1'b0;
      frel_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      ptr_p0   <= ptr_nxt;
      hold_p0  <= hold_nxt;
      gnt_p0   <= gnt_nxt;
      idx_p0   <= idx_nxt;
      vld_p0   <= vld_nxt;
      frel_p0  <= frel_nxt;
    end
  end

  assign bus.gnt        = gnt_p0;
  assign bus.gnt_idx    = idx_p0;
  assign bus.gnt_vld    = vld_p0;
  assign bus.forced_rel = frel_p0;

endmodule

// File: tb/tb_rr_grant_arbiter8.sv
// tb_rr_grant_arbiter8
//   Directed bench for rr_grant_arbiter8 built with MAX_HOLD=4. Each task
//   applies a request sequence one clock at a time and compares the grant
//   outputs against hand-computed tables, sampling 1 time unit after the
//   rising edge.
module tb_rr_grant_arbiter8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  rr_grant_arbiter8_if bus ();

  rr_grant_arbiter8 #(
    .MAX_HOLD (4),
    .CNT_W    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input logic [7:0] r);
    bus.req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.en = 1'b1;
    rst    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(8'hFF);
      n_checks++;
      if (bus.gnt !== 8'h00 || bus.gnt_vld !== 1'b0 || bus.forced_rel !== 1'b0) begin
        n_fail++;
        $display("FAIL reset cyc %0d: gnt=%h vld=%b fr=%b, want gnt=00 vld=0 fr=0",
                 i, bus.gnt, bus.gnt_vld, bus.forced_rel);
      end
    end
    rst = 1'b0;
    tick(8'h00);
    n_checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_exit: gnt=%h vld=%b, want gnt=00 vld=0", bus.gnt, bus.gnt_vld);
    end
  endtask

  // All eight request; each owner drops its request after 2 busy cycles.
  task automatic test_rotation();
    logic [7:0] own;
    logic [7:0] e;
    int         k;
    for (int g = 0; g < 9; g++) begin
      k   = g % 8;
      own = 8'h01 << k;
      for (int c = 0; c < 3; c++) begin
        tick((c == 2) ? (8'hFF & ~own) : 8'hFF);
        e = (c == 2) ? 8'h00 : own;
        n_checks++;
        if (bus.gnt !== e || bus.gnt_vld !== (e != 8'h00) || bus.forced_rel !== 1'b0 ||
            (e != 8'h00 && bus.gnt_idx !== 3'(k))) begin
          n_fail++;
          $display("FAIL rotation grant %0d cyc %0d: gnt=%h vld=%b fr=%b idx=%0d, want gnt=%h idx=%0d",
                   g, c, bus.gnt, bus.gnt_vld, bus.forced_rel, bus.gnt_idx, e, k);
        end
      end
    end
  endtask

  // Single requester 4 for three cycles, then a ptr probe: with ptr=5,
  // req=8'h50 must pick 6 rather than 4.
  task automatic test_single();
    logic [7:0] rq [7] = '{8'h10, 8'h10, 8'h10, 8'h00, 8'h50, 8'h00, 8'h00};
    logic [7:0] eg [7] = '{8'h10, 8'h10, 8'h10, 8'h00, 8'h40, 8'h00, 8'h00};
    logic [2:0] ei [7] = '{3'd4,  3'd4,  3'd4,  3'd0,  3'd6,  3'd0,  3'd0};
    for (int i = 0; i < 7; i++) begin
      tick(rq[i]);
      n_checks++;
      if (bus.gnt !== eg[i] || bus.gnt_vld !== (eg[i] != 8'h00) || bus.forced_rel !== 1'b0 ||
          (eg[i] != 8'h00 && bus.gnt_idx !== ei[i])) begin
        n_fail++;
        $display("FAIL single cyc %0d: gnt=%h vld=%b fr=%b idx=%0d, want gnt=%h idx=%0d",
                 i, bus.gnt, bus.gnt_vld, bus.forced_rel, bus.gnt_idx, eg[i], ei[i]);
      end
    end
  endtask

  // ptr=7 after serving 6: 7 wins over 0, then 0 wins after the wrap.
  task automatic test_wrap();
    logic [7:0] rq [6] = '{8'h81, 8'h81, 8'h01, 8'h01, 8'h00, 8'h00};
    logic [7:0] eg [6] = '{8'h80, 8'h80, 8'h00, 8'h01, 8'h00, 8'h00};
    logic [2:0] ei [6] = '{3'd7,  3'd7,  3'd0,  3'd0,  3'd0,  3'd0};
    for (int i = 0; i < 6; i++) begin
      tick(rq[i]);
      n_checks++;
      if (bus.gnt !== eg[i] || bus.gnt_vld !== (eg[i] != 8'h00) || bus.forced_rel !== 1'b0 ||
          (eg[i] != 8'h00 && bus.gnt_idx !== ei[i])) begin
        n_fail++;
        $display("FAIL wrap cyc %0d: gnt=%h vld=%b fr=%b idx=%0d, want gnt=%h idx=%0d",
                 i, bus.gnt, bus.gnt_vld, bus.forced_rel, bus.gnt_idx, eg[i], ei[i]);
      end
    end
  endtask

  // Requester 0 holds: 4 grant cycles, forced release, re-grant; the second
  // grant is dropped exactly at the hold limit, so no forced_rel pulse.
  task automatic test_timeout();
    logic [7:0] rq [11] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01,
                            8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
    logic [7:0] eg [11] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01,
                            8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
    logic       ef [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                            1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      tick(rq[i]);
      n_checks++;
      if (bus.gnt !== eg[i] || bus.gnt_vld !== (eg[i] != 8'h00) || bus.forced_rel !== ef[i] ||
          (eg[i] != 8'h00 && bus.gnt_idx !== 3'd0)) begin
        n_fail++;
        $display("FAIL timeout cyc %0d: gnt=%h vld=%b fr=%b idx=%0d, want gnt=%h fr=%b idx=0",
                 i, bus.gnt, bus.gnt_vld, bus.forced_rel, bus.gnt_idx, eg[i], ef[i]);
      end
    end
  endtask

  // en gates only new grants; a non-owner request during a grant is ignored.
  task automatic test_enable();
    logic       ee [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] rq [8] = '{8'h04, 8'h04, 8'h04, 8'h0C, 8'h08, 8'h08, 8'h08, 8'h00};
    logic [7:0] eg [8] = '{8'h00, 8'h00, 8'h04, 8'h04, 8'h00, 8'h00, 8'h08, 8'h00};
    logic [2:0] ei [8] = '{3'd0,  3'd0,  3'd2,  3'd2,  3'd0,  3'd0,  3'd3,  3'd0};
    for (int i = 0; i < 8; i++) begin
      bus.en = ee[i];
      tick(rq[i]);
      n_checks++;
      if (bus.gnt !== eg[i] || bus.gnt_vld !== (eg[i] != 8'h00) || bus.forced_rel !== 1'b0 ||
          (eg[i] != 8'h00 && bus.gnt_idx !== ei[i])) begin
        n_fail++;
        $display("FAIL enable cyc %0d: gnt=%h vld=%b fr=%b idx=%0d, want gnt=%h idx=%0d",
                 i, bus.gnt, bus.gnt_vld, bus.forced_rel, bus.gnt_idx, eg[i], ei[i]);
      end
    end
    bus.en = 1'b1;
  endtask

  // Reset mid-grant clears gnt without waiting for a clock edge and
  // returns priority to requester 0.
  task automatic test_reset_mid_grant();
    tick(8'h20);
    n_checks++;
    if (bus.gnt !== 8'h20 || bus.gnt_idx !== 3'd5) begin
      n_fail++;
      $display("FAIL midrst_grant: gnt=%h idx=%0d, want gnt=20 idx=5", bus.gnt, bus.gnt_idx);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: gnt=%h vld=%b, want gnt=00 vld=0", bus.gnt, bus.gnt_vld);
    end
    for (int i = 0; i < 2; i++) begin
      tick(8'h21);
      n_checks++;
      if (bus.gnt !== 8'h00 || bus.gnt_vld !== 1'b0 || bus.forced_rel !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_hold cyc %0d: gnt=%h vld=%b fr=%b, want all 0",
                 i, bus.gnt, bus.gnt_vld, bus.forced_rel);
      end
    end
    rst = 1'b0;
    tick(8'h21);
    n_checks++;
    if (bus.gnt !== 8'h01 || bus.gnt_vld !== 1'b1 || bus.gnt_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_regrant: gnt=%h vld=%b idx=%0d, want gnt=01 vld=1 idx=0",
               bus.gnt, bus.gnt_vld, bus.gnt_idx);
    end
    tick(8'h00);
    n_checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_release: gnt=%h vld=%b, want gnt=00 vld=0", bus.gnt, bus.gnt_vld);
    end
  endtask

  initial begin
    bus.en  = 1'b1;
    bus.req = 8'hFF;
    test_reset();
    test_rotation();
    test_single();
    test_wrap();
    test_timeout();
    test_enable();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
